fb_scan_ctrl: RTL and testbench



---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_scan_ctrl_if.sv | 26 ++
 rtl/fb_div.sv | 42 ++++
 rtl/fb_scan_ctrl.sv | 101 ++++++++++
 tb/tb_fb_scan_ctrl.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, geometry record and FSM states for the framebuffer scan controller
package fb_pkg;
  localparam int OUT_W = 1280;
  localparam int OUT_H = 720;
  localparam int OVL_W = 256;
  localparam int OVL_H = 224;
  typedef struct packed {
    logic [10:0] w;
    logic [9:0]  h;
    logic [10:0] ws;
    logic [10:0] xstart;
    logic [10:0] xstop;
  } fb_geom_t;
  typedef enum logic [1:0] {IDLE, MUL, DIV, APPLY} geom_state_t;
  function automatic int fb_awidth(input int width, input int height);
    return $clog2(width * height);
  endfunction
endpackage

// File: rtl/fb_scan_ctrl_if.sv
// fb_scan_ctrl_if: raster/geometry inputs and framebuffer read-side outputs of fb_scan_ctrl
interface fb_scan_ctrl_if #(
  parameter int WIDTH = 320,
  parameter int HEIGHT = 240
);
  localparam int AW = fb_pkg::fb_awidth(WIDTH, HEIGHT);
  logic [10:0] cx;
  logic [9:0] cy;
  logic [10:0] src_w;
  logic [9:0] src_h;
  logic overlay;
  logic [AW-1:0] fb_addr;
  logic [$clog2(WIDTH)-1:0] src_x;
  logic [$clog2(HEIGHT)-1:0] src_y;
  logic active;
  logic pix_valid;
  logic geom_busy;
  modport master(
    output cx, cy, src_w, src_h, overlay,
    input fb_addr, src_x, src_y, active, pix_valid, geom_busy
  );
  modport slave(
    input cx, cy, src_w, src_h, overlay,
    output fb_addr, src_x, src_y, active, pix_valid, geom_busy
  );
endinterface

// File: rtl/fb_div.sv
// fb_div: sequential unsigned restoring divider, one quotient bit per cycle, first bit on the start cycle
module fb_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [20:0] dividend,
  input  logic [9:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [20:0] quotient
);
  logic [9:0] rem, d, r_in, d_in, r_n;
  logic [20:0] q_in, q_n;
  logic [10:0] t;
  logic [4:0] cnt;
  logic ge;
  always_comb begin
    r_in = start ? '0 : rem;
    q_in = start ? dividend : quotient;
    d_in = start ? divisor : d;
    t = {r_in, q_in[20]};
    ge = t >= {1'b0, d_in};
    r_n = ge ? 10'(t - {1'b0, d_in}) : t[9:0];
    q_n = {q_in[19:0], ge};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
    end else begin
      done <= busy && cnt == 5'd20;
      busy <= start || (busy && cnt != 5'd20);
      if (start || busy) begin
        rem <= r_n;
        quotient <= q_n;
        cnt <= start ? 5'd1 : cnt + 5'd1;
      end
      if (start) d <= divisor;
    end
  end
endmodule

// File: rtl/fb_scan_ctrl.sv
// fb_scan_ctrl: maps HDMI raster position to framebuffer read address with per-frame scaled geometry
module fb_scan_ctrl
  import fb_pkg::*;
#(
  parameter int WIDTH = 320,
  parameter int HEIGHT = 240
) (
  input logic clk_pixel,
  input logic reset,
  fb_scan_ctrl_if.slave bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = fb_awidth(WIDTH, HEIGHT);
  localparam int WS0 = WIDTH * OUT_H / HEIGHT;
  localparam int XS0 = (OUT_W - WS0) / 2;
  localparam fb_geom_t GEOM0 = '{w: 11'(WIDTH), h: 10'(HEIGHT), ws: 11'(WS0), xstart: 11'(XS0), xstop: 11'(XS0 + WS0)};
  geom_state_t state;
  fb_geom_t g;
  logic [10:0] pw, sw, ws_n, xs_n, xcnt, ycnt, xsum, ysum, nxc, nyc;
  logic [9:0] ph, sh;
  logic [20:0] prod, quo;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic bad, latch, div_busy, div_done, in_win, row_tick, act_n;
  assign sw = bus.overlay ? 11'(OVL_W) : bus.src_w;
  assign sh = bus.overlay ? 10'(OVL_H) : bus.src_h;
  assign bad = sw == '0 || sh == '0 || sw > 11'(WIDTH) || sh > 10'(HEIGHT);
  assign latch = bus.cx == '0 && bus.cy == 10'(OUT_H);
  assign prod = 21'(pw) * 21'(OUT_H);
  assign ws_n = quo > 21'(OUT_W) ? 11'(OUT_W) : quo[10:0];
  assign xs_n = (11'(OUT_W) - ws_n) >> 1;
  fb_div u_div (
    .clk(clk_pixel),
    .rst(reset),
    .start(state == MUL),
    .dividend(prod),
    .divisor(ph),
    .busy(div_busy),
    .done(div_done),
    .quotient(quo)
  );
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state <= IDLE;
      g <= GEOM0;
      pw <= 11'(WIDTH);
      ph <= 10'(HEIGHT);
      bus.geom_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (latch) begin
          pw <= bad ? 11'(WIDTH) : sw;
          ph <= bad ? 10'(HEIGHT) : sh;
          state <= MUL;
          bus.geom_busy <= 1'b1;
        end
        MUL: state <= DIV;
        DIV: if (div_done && !div_busy) state <= APPLY;
        default: begin
          g <= '{w: pw, h: ph, ws: ws_n, xstart: xs_n, xstop: xs_n + ws_n};
          state <= IDLE;
          bus.geom_busy <= 1'b0;
        end
      endcase
    end
  end
  // Fractional-step accumulators: h source pixels spread over OUT_H output pixels
  always_comb begin
    in_win = bus.cx >= g.xstart && bus.cx < g.xstop && g.ws != '0;
    row_tick = bus.cx == '0 && bus.cy != '0 && bus.cy < 10'(OUT_H);
    act_n = in_win && bus.cy < 10'(OUT_H);
    xsum = xcnt + 11'(g.h);
    ysum = ycnt + 11'(g.h);
    nxc = bus.cx == '0 ? '0 : !in_win ? xcnt : xsum >= 11'(OUT_H) ? xsum - 11'(OUT_H) : xsum;
    nx = bus.cx == '0 ? '0 :
         in_win && xsum >= 11'(OUT_H) && 11'(bus.src_x) < g.w - 11'd1 ? bus.src_x + XW'(1) : bus.src_x;
    nyc = bus.cx == '0 && bus.cy == '0 ? '0 : !row_tick ? ycnt : ysum >= 11'(OUT_H) ? ysum - 11'(OUT_H) : ysum;
    ny = bus.cx == '0 && bus.cy == '0 ? '0 :
         row_tick && ysum >= 11'(OUT_H) && 10'(bus.src_y) < g.h - 10'd1 ? bus.src_y + YW'(1) : bus.src_y;
  end
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      xcnt <= '0;
      ycnt <= '0;
      bus.src_x <= '0;
      bus.src_y <= '0;
      bus.fb_addr <= '0;
      bus.active <= 1'b0;
      bus.pix_valid <= 1'b0;
    end else begin
      xcnt <= nxc;
      ycnt <= nyc;
      bus.src_x <= nx;
      bus.src_y <= ny;
      bus.active <= act_n;
      bus.pix_valid <= bus.active;
      if (act_n) bus.fb_addr <= AW'(32'(ny) * WIDTH + 32'(nx));
    end
  end
endmodule

// File: tb/tb_fb_scan_ctrl.sv
// tb_fb_scan_ctrl: scoreboard bench driving abbreviated raster frames and geometry latches
module tb_fb_scan_ctrl;
  typedef struct {int act, pv, gb, sx, sy, addr;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int gw, gh, gxs, gxe, pw, ph, geo_cnt, sx, sy, addr, pact, act_cnt, gb_cnt;
  fb_scan_ctrl_if #(.WIDTH(320), .HEIGHT(240)) bif();
  fb_scan_ctrl #(.WIDTH(320), .HEIGHT(240)) dut (.clk_pixel(clk), .reset(reset), .bus(bif));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cx=%0d cy=%0d)", tag, got, exp, bif.cx, bif.cy);
    end
  endtask
  function automatic int imin(input int a, input int b);
    return a < b ? a : b;
  endfunction
  function automatic void set_geom(input int w, input int h);
    int ws;
    ws = imin(w * 720 / h, 1280);
    gw = w;
    gh = h;
    gxs = (1280 - ws) / 2;
    gxe = gxs + ws;
  endfunction
  // Closed-form reference: k in-window cycles give floor(k*h/720) source pixels
  task automatic step(input int x, input int y);
    exp_t e;
    bit in_w;
    bif.cx = 11'(x);
    bif.cy = 10'(y);
    if (reset) begin
      set_geom(320, 240);
      geo_cnt = 0;
      sx = 0;
      sy = 0;
      addr = 0;
      pact = 0;
      e = '{0, 0, 0, 0, 0, 0};
    end else begin
      e.gb = 0;
      if (geo_cnt > 0) begin
        geo_cnt--;
        if (geo_cnt == 0) set_geom(pw, ph);
        e.gb = int'(geo_cnt >= 2);
      end
      if (x == 0 && y == 720 && geo_cnt == 0) begin
        int w, h;
        w = bif.overlay ? 256 : int'(bif.src_w);
        h = bif.overlay ? 224 : int'(bif.src_h);
        if (w == 0 || h == 0 || w > 320 || h > 240) begin
          w = 320;
          h = 240;
        end
        pw = w;
        ph = h;
        geo_cnt = 24;
        e.gb = 1;
      end
      in_w = x >= gxs && x < gxe;
      if (x == 0) sx = 0;
      else if (in_w) sx = imin((x - gxs + 1) * gh / 720, gw - 1);
      if (x == 0 && y == 0) sy = 0;
      else if (x == 0 && y < 720) sy = imin(y * gh / 720, gh - 1);
      e.act = int'(in_w && y < 720);
      if (e.act != 0) addr = sy * 320 + sx;
      e.pv = pact;
      pact = e.act;
      e.sx = sx;
      e.sy = sy;
      e.addr = addr;
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check("active", 32'(bif.active), e.act);
    check("pix_valid", 32'(bif.pix_valid), e.pv);
    check("geom_busy", 32'(bif.geom_busy), e.gb);
    check("src_x", 32'(bif.src_x), e.sx);
    check("src_y", 32'(bif.src_y), e.sy);
    check("fb_addr", 32'(bif.fb_addr), e.addr);
    act_cnt += int'(bif.active);
    gb_cnt += int'(bif.geom_busy);
  endtask
  task automatic row(input int y);
    for (int x = 0; x < 1290; x++) step(x, y);
  endtask
  task automatic frame(input int ws, input int last);
    bif.src_w = 11'd100;
    bif.src_h = 10'd50;
    bif.overlay = 1'b0;
    for (int y = 0; y < 720; y++) begin
      if (y == 0 || y == 3 || y == 719) begin
        act_cnt = 0;
        row(y);
        check("window_len", act_cnt, ws);
      end else step(0, y);
    end
    check("last_addr", 32'(bif.fb_addr), last);
  endtask
  task automatic latch(input int w, input int h, input bit ovl);
    bif.src_w = 11'(w);
    bif.src_h = 10'(h);
    bif.overlay = ovl;
    gb_cnt = 0;
    for (int x = 0; x < 41; x++) step(x, 720);
    check("busy_len", gb_cnt, 23);
  endtask
  initial begin
    bif.cx = '0;
    bif.cy = '0;
    bif.src_w = 11'd320;
    bif.src_h = 10'd240;
    bif.overlay = 1'b0;
    @(negedge clk);
    step(0, 0);
    step(0, 0);
    reset = 1'b0;
    frame(960, 76799);
    latch(256, 224, 1'b0);
    frame(822, 71615);
    latch(320, 240, 1'b1);
    frame(822, 71615);
    latch(320, 224, 1'b0);
    frame(1028, 71679);
    latch(320, 0, 1'b0);
    frame(960, 76799);
    latch(320, 224, 1'b0);
    frame(1028, 71679);
    latch(400, 240, 1'b0);
    frame(960, 76799);
    bif.src_w = 11'd256;
    bif.src_h = 10'd224;
    for (int x = 0; x < 6; x++) step(x, 720);
    reset = 1'b1;
    step(6, 720);
    check("busy_after_reset", 32'(bif.geom_busy), 0);
    reset = 1'b0;
    for (int x = 7; x < 41; x++) step(x, 720);
    frame(960, 76799);
    latch(256, 224, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
